exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline. It consumes everything the ID/EX pipeline register presents.
- Computes the second operand (Val2), the ALU result and the branch target.
- Owns the architectural status register (NZCV), which is fed back to the ID-stage condition checker.
- Sits between the ID/EX register and the EX/MEM register. Only the status register is sequential; all other outputs are combinational.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous active-low reset.
- freeze  in  1  pipeline stall; blocks the status-register update.
- flush  in  1  current EX instruction squashed; blocks the status-register update.
- EXE_CMD_In  in  4  ALU command from ID/EX.
- MEM_R_EN_In  in  1  load instruction.
- MEM_W_EN_In  in  1  store instruction.
- S_In  in  1  update-flags bit.
- imm_In  in  1  Val2 comes from the rotated immediate.
- PC_In  in  32  PC+4 of the instruction.
- Val_Rn_In  in  32  first operand.
- Val_Rm_In  in  32  register operand for Val2.
- Shift_operand_In  in  12  shifter operand field.
- Signed_imm_24_In  in  24  branch offset.
- ALU_Res_Out  out  32  ALU result (memory address for LDR/STR).
- Br_Addr_Out  out  32  branch target.
- Status_Out  out  4  registered {N,Z,C,V}.

Behaviour:
- Reset: while RST=0, Status_Out=4'b0000 asynchronously. All other outputs are combinational and not reset.

Val2 generation, evaluated in priority order:
- If MEM_R_EN_In or MEM_W_EN_In: Val2 = zero-extended Shift_operand_In[11:0].
- Else if imm_In: Val2 = {24'b0, Shift_operand_In[7:0]} rotated right by 2×Shift_operand_In[11:8]. A rotate amount of 0 passes the value unchanged.
- Else: shift Val_Rm_In by shift_imm = Shift_operand_In[11:7] according to type Shift_operand_In[6:5]:
  - 00 LSL
  - 01 LSR (logical)
  - 10 ASR (sign-filling)
  - 11 ROR
  - shift_imm=0 passes Val_Rm_In unchanged for every type.

ALU commands (C_in = Status_Out[1]):
- 0001 MOV: Val2
- 1001 MVN: ~Val2
- 0010 ADD (also LDR/STR): Rn+Val2
- 0011 ADC: Rn+Val2+C_in
- 0100 SUB/CMP: Rn−Val2
- 0101 SBC: Rn−Val2−(~C_in)
- 0110 AND/TST: Rn&Val2
- 0111 ORR: Rn|Val2
- 1000 EOR: Rn^Val2
- Any other code: result 0, and the flags are treated as from a logical op.

Flag rules:
- N = res[31]; Z = (res==0).
- ADD/ADC: C = carry out of bit 31; V = (Rn[31]==Val2[31]) && (res[31]!=Rn[31]).
- SUB/SBC: C = NOT borrow (ARM convention); V = (Rn[31]!=Val2[31]) && (res[31]!=Rn[31]).
- MOV, MVN, logical ops: C and V keep their current register values.

Status register:
- On the rising CLK edge, loads {N,Z,C,V} iff S_In=1 && freeze=0 && flush=0. Otherwise it holds.
- If freeze and flush are both 1, the register holds.
- Reset asserted mid-operation overrides any pending update.

Branch target:
- Br_Addr_Out = PC_In + (sign-extend(Signed_imm_24_In) << 2), computed modulo 2^32.
- Wrap-around is silent.

Width rule: all arithmetic is 32-bit, with the carry taken from a 33-bit sum.

Latency:
- ALU_Res_Out and Br_Addr_Out are valid in the same cycle as their inputs.
- Status_Out reflects an instruction's flags from the following cycle.

Test Plan:
- Reset: hold RST=0 with S_In=1 across edges -> Status_Out=0000. Release RST, then ADD Rn=1, Val2=1, S=1 -> after the edge, Status_Out=0000 and ALU_Res_Out=2.
- Carry/overflow: ADD Rn=0x7FFFFFFF, imm Val2=1, S=1 -> res 0x80000000, NZCV=1001. Then ADD Rn=0xFFFFFFFF, Val2=1 -> res 0, NZCV=0110. Then ADC Rn=0, Val2=0 -> res 1.
- Compare: CMP Rn=5, Val2=5, S=1 -> NZCV=0110. SUB Rn=3, Val2=5 -> res 0xFFFFFFFE, NZCV=1000.
- Val2 generator:
  - imm_In=1, Shift_operand=0x4FF -> Val2=0xFF000000.
  - Rm=0x80000000, ASR by 4 -> 0xF8000000.
  - Rm=0x80000000, LSR by 4 -> 0x08000000.
  - Rm=0x00000001, ROR by 1 -> 0x80000000.
  - MEM_W_EN=1, Shift_operand=0xFFF -> ALU_Res = Rn+0xFFF.
- Freeze/flush: S_In=1 with freeze=1, then with flush=1 -> Status_Out unchanged. Dropping both -> update on the next edge. AND with S=1 leaves C and V unchanged.
- Branch: PC_In=0x100, imm24=0xFFFFFE -> Br_Addr_Out=0xF8. imm24=0x000003 -> 0x10C. PC_In=0xFFFFFFFC, imm24=1 -> 0x0.

Source files
------------

// File: rtl/exe_stage_if.sv
// Operand and result bundle between the ID/EX register, the execute stage and the EX/MEM register.
// The master drives the decoded instruction fields; the execute stage (slave) returns the results and flags.
interface exe_stage_if;
  logic [3:0]  EXE_CMD_In;
  logic        MEM_R_EN_In;
  logic        MEM_W_EN_In;
  logic        S_In;
  logic        imm_In;
  logic [31:0] PC_In;
  logic [31:0] Val_Rn_In;
  logic [31:0] Val_Rm_In;
  logic [11:0] Shift_operand_In;
  logic [23:0] Signed_imm_24_In;
  logic [31:0] ALU_Res_Out;
  logic [31:0] Br_Addr_Out;
  logic [3:0]  Status_Out;

  modport master (
    output EXE_CMD_In, MEM_R_EN_In, MEM_W_EN_In, S_In, imm_In, PC_In,
           Val_Rn_In, Val_Rm_In, Shift_operand_In, Signed_imm_24_In,
    input  ALU_Res_Out, Br_Addr_Out, Status_Out
  );

  modport slave (
    input  EXE_CMD_In, MEM_R_EN_In, MEM_W_EN_In, S_In, imm_In, PC_In,
           Val_Rn_In, Val_Rm_In, Shift_operand_In, Signed_imm_24_In,
    output ALU_Res_Out, Br_Addr_Out, Status_Out
  );
endinterface

// File: rtl/exe_stage.sv
// ARM execute stage: Val2 shifter, ALU, branch-target adder and the NZCV status register.
// Only the status register is clocked; every other output follows its inputs combinationally.
module exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        freeze,
  input  logic        flush,
  exe_stage_if.slave  bus
);
  logic [WIDTH-1:0] val2;
  logic [WIDTH-1:0] rn;
  logic [WIDTH-1:0] rm;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] imm_rot;
  logic [2*WIDTH-1:0] rm_ror;
  logic [5:0]       rot_amt;
  logic [4:0]       shift_imm;
  logic [3:0]       status;
  logic             c_in;
  logic             n_flag, z_flag, c_flag, v_flag;

  assign rn        = bus.Val_Rn_In;
  assign rm        = bus.Val_Rm_In;
  assign c_in      = status[1];
  assign shift_imm = bus.Shift_operand_In[11:7];
  assign rot_amt   = {bus.Shift_operand_In[11:8], 1'b0};
  // Rotations are done by shifting a doubled word; the low half is the rotated value.
  assign imm_rot   = {2{24'b0, bus.Shift_operand_In[7:0]}} >> rot_amt;
  assign rm_ror    = {rm, rm} >> shift_imm;

  always_comb begin
    val2 = rm;
    if (bus.MEM_R_EN_In || bus.MEM_W_EN_In) begin
      val2 = {20'b0, bus.Shift_operand_In};
    end else if (bus.imm_In) begin
      val2 = imm_rot[WIDTH-1:0];
    end else begin
      case (bus.Shift_operand_In[6:5])
        2'b00:   val2 = rm << shift_imm;
        2'b01:   val2 = rm >> shift_imm;
        2'b10:   val2 = $unsigned($signed(rm) >>> shift_imm);
        default: val2 = rm_ror[WIDTH-1:0];
      endcase
    end
  end

  always_comb begin
    sum    = '0;
    res    = '0;
    c_flag = status[1];
    v_flag = status[0];
    case (bus.EXE_CMD_In)
      4'b0001: res = val2;
      4'b1001: res = ~val2;
      4'b0010, 4'b0011: begin
        sum    = {1'b0, rn} + {1'b0, val2} +
                 {{WIDTH{1'b0}}, (bus.EXE_CMD_In == 4'b0011) ? c_in : 1'b0};
        res    = sum[WIDTH-1:0];
        c_flag = sum[WIDTH];
        v_flag = (rn[WIDTH-1] == val2[WIDTH-1]) && (res[WIDTH-1] != rn[WIDTH-1]);
      end
      4'b0100, 4'b0101: begin
        // Subtract as Rn + ~Val2 + carry-in so the carry out is the ARM "not borrow".
        sum    = {1'b0, rn} + {1'b0, ~val2} +
                 {{WIDTH{1'b0}}, (bus.EXE_CMD_In == 4'b0101) ? c_in : 1'b1};
        res    = sum[WIDTH-1:0];
        c_flag = sum[WIDTH];
        v_flag = (rn[WIDTH-1] != val2[WIDTH-1]) && (res[WIDTH-1] != rn[WIDTH-1]);
      end
      4'b0110: res = rn & val2;
      4'b0111: res = rn | val2;
      4'b1000: res = rn ^ val2;
      default: res = '0;
    endcase
    n_flag = res[WIDTH-1];
    z_flag = (res == '0);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      status <= 4'b0000;
    end else if (bus.S_In && !freeze && !flush) begin
      status <= {n_flag, z_flag, c_flag, v_flag};
    end
  end

  assign bus.ALU_Res_Out = res;
  assign bus.Status_Out  = status;
  assign bus.Br_Addr_Out = bus.PC_In + {{6{bus.Signed_imm_24_In[23]}}, bus.Signed_imm_24_In, 2'b00};
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: an arithmetic reference model checked every cycle plus hand-computed literals.
module tb_exe_stage;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic freeze = 1'b0;
  logic flush = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [3:0] m_status;

  exe_stage_if bus();

  exe_stage #(.WIDTH(32)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .freeze (freeze),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_val2(input logic mem, input logic imm,
                                         input logic [31:0] rm, input logic [11:0] op);
    logic [31:0] v;
    int n;
    if (mem) return {20'b0, op};
    if (imm) begin
      v = {24'b0, op[7:0]};
      n = 2 * int'(op[11:8]);
      for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
      return v;
    end
    v = rm;
    n = int'(op[11:7]);
    for (int i = 0; i < n; i++) begin
      case (op[6:5])
        2'b00:   v = {v[30:0], 1'b0};
        2'b01:   v = {1'b0, v[31:1]};
        2'b10:   v = {v[31], v[31:1]};
        default: v = {v[0], v[31:1]};
      endcase
    end
    return v;
  endfunction

  function automatic void m_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                                input logic [3:0] st, output logic [31:0] res, output logic [3:0] nzcv);
    logic [63:0] wide;
    logic c, v, cin;
    cin = st[1];
    c = st[1];
    v = st[0];
    res = 32'h0;
    case (cmd)
      4'b0001: res = v2;
      4'b1001: res = ~v2;
      4'b0010, 4'b0011: begin
        wide = 64'(rn) + 64'(v2) + ((cmd == 4'b0011) ? 64'(cin) : 64'd0);
        res = wide[31:0];
        c = (wide > 64'h0000_0000_FFFF_FFFF);
        v = (rn[31] == v2[31]) && (res[31] != rn[31]);
      end
      4'b0100, 4'b0101: begin
        wide = 64'(v2) + ((cmd == 4'b0101) ? 64'(!cin) : 64'd0);
        res = rn - wide[31:0];
        c = (64'(rn) >= wide);
        v = (rn[31] != v2[31]) && (res[31] != rn[31]);
      end
      4'b0110: res = rn & v2;
      4'b0111: res = rn | v2;
      4'b1000: res = rn ^ v2;
      default: res = 32'h0;
    endcase
    nzcv = {res[31], res == 32'h0, c, v};
  endfunction

  function automatic logic [31:0] m_res_now();
    logic [31:0] r;
    logic [3:0] f;
    m_alu(bus.EXE_CMD_In, bus.Val_Rn_In,
          m_val2(bus.MEM_R_EN_In | bus.MEM_W_EN_In, bus.imm_In, bus.Val_Rm_In, bus.Shift_operand_In),
          m_status, r, f);
    return r;
  endfunction

  function automatic logic [3:0] m_flags_now();
    logic [31:0] r;
    logic [3:0] f;
    m_alu(bus.EXE_CMD_In, bus.Val_Rn_In,
          m_val2(bus.MEM_R_EN_In | bus.MEM_W_EN_In, bus.imm_In, bus.Val_Rm_In, bus.Shift_operand_In),
          m_status, r, f);
    return f;
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) m_status = 4'b0000;
    else if (bus.S_In && !freeze && !flush) m_status = m_flags_now();
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    check("model_alu", bus.ALU_Res_Out, m_res_now());
    check("model_br", bus.Br_Addr_Out,
          bus.PC_In + {{6{bus.Signed_imm_24_In[23]}}, bus.Signed_imm_24_In, 2'b00});
    check("model_status", {28'b0, bus.Status_Out}, {28'b0, m_status});
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [3:0] cmd, input logic mr, input logic mw, input logic s,
                       input logic imm, input logic [31:0] rn, input logic [31:0] rm,
                       input logic [11:0] op);
    bus.EXE_CMD_In = cmd;
    bus.MEM_R_EN_In = mr;
    bus.MEM_W_EN_In = mw;
    bus.S_In = s;
    bus.imm_In = imm;
    bus.Val_Rn_In = rn;
    bus.Val_Rm_In = rm;
    bus.Shift_operand_In = op;
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic edge_();
    @(posedge CLK);
    #1;
  endtask

  task automatic branch(input logic [31:0] pc, input logic [23:0] off, input logic [31:0] exp);
    bus.PC_In = pc;
    bus.Signed_imm_24_In = off;
    #1;
    check("branch", bus.Br_Addr_Out, exp);
  endtask

  initial begin
    bus.PC_In = 32'h0;
    bus.Signed_imm_24_In = 24'h0;
    drive(4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1, 32'h0, 12'h001);

    // Reset held across edges with S=1
    edge_();
    edge_();
    check("reset_status", {28'b0, bus.Status_Out}, 32'h0);
    RST = 1'b1;
    step();
    check("add_1_1", bus.ALU_Res_Out, 32'h2);
    edge_();
    check("add_1_1_nzcv", {28'b0, bus.Status_Out}, 32'h0);

    // Carry / overflow
    drive(4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0, 12'h001);
    step();
    check("add_ovf_res", bus.ALU_Res_Out, 32'h8000_0000);
    edge_();
    check("add_ovf_nzcv", {28'b0, bus.Status_Out}, 32'h9);
    drive(4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0, 12'h001);
    step();
    check("add_carry_res", bus.ALU_Res_Out, 32'h0);
    edge_();
    check("add_carry_nzcv", {28'b0, bus.Status_Out}, 32'h6);
    drive(4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 12'h000);
    step();
    check("adc_cin", bus.ALU_Res_Out, 32'h1);
    edge_();

    // Subtract / compare
    drive(4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3, 32'h0, 12'h005);
    step();
    check("sub_res", bus.ALU_Res_Out, 32'hFFFF_FFFE);
    edge_();
    check("sub_nzcv", {28'b0, bus.Status_Out}, 32'h8);
    drive(4'b0101, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 12'h003);
    step();
    check("sbc_borrow", bus.ALU_Res_Out, 32'hC);
    edge_();
    drive(4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5, 32'h0, 12'h005);
    step();
    check("cmp_res", bus.ALU_Res_Out, 32'h0);
    edge_();
    check("cmp_nzcv", {28'b0, bus.Status_Out}, 32'h6);

    // Val2 generator through MOV
    drive(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 12'h4FF);
    step();
    check("imm_rot", bus.ALU_Res_Out, 32'hFF00_0000);
    drive(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 12'h240);
    step();
    check("asr4", bus.ALU_Res_Out, 32'hF800_0000);
    drive(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 12'h220);
    step();
    check("lsr4", bus.ALU_Res_Out, 32'h0800_0000);
    drive(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0001, 12'h0E0);
    step();
    check("ror1", bus.ALU_Res_Out, 32'h8000_0000);
    drive(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 12'h060);
    step();
    check("ror0_pass", bus.ALU_Res_Out, 32'h1234_5678);
    drive(4'b0010, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 12'hFFF);
    step();
    check("store_addr", bus.ALU_Res_Out, 32'h1FFF);
    drive(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_00FF, 12'h000);
    step();
    check("mvn", bus.ALU_Res_Out, 32'hFFFF_FF00);
    drive(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hF0F0, 32'h0000_0001, 12'h200);
    step();
    check("eor_lsl4", bus.ALU_Res_Out, 32'hF0E0);
    edge_();

    // Freeze / flush block the update (status is 0110 here)
    drive(4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0, 12'h001);
    freeze = 1'b1;
    edge_();
    check("freeze_hold", {28'b0, bus.Status_Out}, 32'h6);
    freeze = 1'b0;
    flush = 1'b1;
    edge_();
    check("flush_hold", {28'b0, bus.Status_Out}, 32'h6);
    freeze = 1'b1;
    edge_();
    check("both_hold", {28'b0, bus.Status_Out}, 32'h6);
    freeze = 1'b0;
    flush = 1'b0;
    edge_();
    check("release_update", {28'b0, bus.Status_Out}, 32'h9);
    drive(4'b0110, 1'b0, 1'b0, 1'b1, 1'b1, 32'hF0, 32'h0, 12'h00F);
    edge_();
    check("and_keeps_cv", {28'b0, bus.Status_Out}, 32'h5);
    drive(4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234, 32'h5678, 12'h000);
    step();
    check("bad_cmd_res", bus.ALU_Res_Out, 32'h0);
    edge_();
    check("bad_cmd_nzcv", {28'b0, bus.Status_Out}, 32'h5);

    // Reset in the middle of a pending update
    drive(4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0, 12'h001);
    step();
    RST = 1'b0;
    #1;
    check("async_reset", {28'b0, bus.Status_Out}, 32'h0);
    edge_();
    check("reset_over_update", {28'b0, bus.Status_Out}, 32'h0);
    step();
    RST = 1'b1;

    // Branch target
    drive(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 12'h000);
    branch(32'h0000_0100, 24'hFF_FFFE, 32'h0000_00F8);
    branch(32'h0000_0100, 24'h00_0003, 32'h0000_010C);
    branch(32'hFFFF_FFFC, 24'h00_0001, 32'h0000_0000);
    branch(32'h0000_0000, 24'h80_0000, 32'hFE00_0000);
    step();
    edge_();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
